// File: rtl/synchronous_fifo_flags_pkg.sv
// Shared types and width helpers for the flagged synchronous FIFO.
// Optional error flags are compiled in with SYNC_FIFO_ERR_EN.
package synchronous_fifo_pkg;

    // Pointer and count width: one extra bit so a full FIFO is distinguishable from empty.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/synchronous_fifo_flags_if.sv
// Producer/consumer bus of the flagged synchronous FIFO.
// err_clr/overflow/underflow exist only when SYNC_FIFO_ERR_EN is defined.
interface synchronous_fifo_flags_if #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
);
    import synchronous_fifo_pkg::*;

    localparam int CNT_W = cnt_width(DEPTH);

    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
`ifdef SYNC_FIFO_ERR_EN
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, r_en, data_in, err_clr,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  w_en, r_en, data_in, err_clr,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
`else
    modport master (
        output w_en, r_en, data_in,
        input  data_out, full, empty, almost_full, almost_empty, count
    );
    modport slave (
        input  w_en, r_en, data_in,
        output data_out, full, empty, almost_full, almost_empty, count
    );
`endif

endinterface

// File: rtl/synchronous_fifo_flags_mem.sv
// Storage array for the flagged FIFO: one write port, one registered read port.
// The read register resets to zero; the array itself is never reset.
module synchronous_fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read: a same-address write in the same cycle is not forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/synchronous_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and
// accepted write-while-full when paired with a read. SYNC_FIFO_ERR_EN adds sticky error flags.
module synchronous_fifo_flags
    import synchronous_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic                    clk,
    input logic                    rst,
    synchronous_fifo_flags_if.slave bus
);

    localparam int PTR_W  = cnt_width(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_LEVEL);

    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] count_q;
    fifo_status_t     status;
    logic             rd_ok;
    logic             wr_ok;

    // Flags come only from registered pointers and count, never from w_en/r_en.
    assign status.empty        = (w_ptr == r_ptr);
    assign status.full         = (w_ptr == {~r_ptr[PTR_W-1], r_ptr[ADDR_W-1:0]});
    assign status.almost_full  = (count_q >= AF_C);
    assign status.almost_empty = (count_q <= AE_C);

    assign rd_ok = bus.r_en && !status.empty;
    assign wr_ok = bus.w_en && (!status.full || rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    synchronous_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (w_ptr[ADDR_W-1:0]),
        .wdata (bus.data_in),
        .re    (rd_ok),
        .raddr (r_ptr[ADDR_W-1:0]),
        .rdata (bus.data_out)
    );

    assign bus.full         = status.full;
    assign bus.empty        = status.empty;
    assign bus.almost_full  = status.almost_full;
    assign bus.almost_empty = status.almost_empty;
    assign bus.count        = count_q;

`ifdef SYNC_FIFO_ERR_EN
    fifo_err_t err_q;

    // A rejection in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            if (bus.w_en && !wr_ok) begin
                err_q.overflow <= 1'b1;
            end else if (bus.err_clr) begin
                err_q.overflow <= 1'b0;
            end
            if (bus.r_en && !rd_ok) begin
                err_q.underflow <= 1'b1;
            end else if (bus.err_clr) begin
                err_q.underflow <= 1'b0;
            end
        end
    end

    assign bus.overflow  = err_q.overflow;
    assign bus.underflow = err_q.underflow;
`endif

endmodule

// File: doc/synchronous_fifo_flags.md
# synchronous_fifo_flags

Parametrised single-clock FIFO that succeeds the basic synchronous FIFO. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and defined simultaneous read/write at the full boundary. Optional sticky overflow/underflow error flags are compiled in by macro. It sits between a producer and a consumer in the same clock domain, used as an elastic buffer and a rate-matching stage.

## Interface
Parameters:
- DEPTH, 16: number of entries; power of two, ≥ 2.
- DATA_WIDTH, 32: width of data_in and data_out.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.

Ports (CNT_W = $clog2(DEPTH)+1):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- w_en  in  1  write request.
- r_en  in  1  read request.
- data_in  in  DATA_WIDTH  write data, sampled on an accepted write.
- data_out  out  DATA_WIDTH  registered read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- err_clr  in  1  clears the error flags (only with SYNC_FIFO_ERR_EN).
- overflow  out  1  sticky write-rejected flag (only with SYNC_FIFO_ERR_EN).
- underflow  out  1  sticky read-rejected flag (only with SYNC_FIFO_ERR_EN).

## Operation
- Pointers: w_ptr and r_ptr are each $clog2(DEPTH)+1 bits. The MSB is the wrap bit. The pointers wrap naturally modulo 2·DEPTH.
- Read accept: rd_ok = r_en && !empty. A read is never bypassed from a same-cycle write.
- Write accept: wr_ok = w_en && (!full || rd_ok). A write while full is accepted only when a read is accepted in the same cycle.
- On wr_ok: mem[w_ptr low bits] ← data_in, and w_ptr increments.
- On rd_ok: data_out ← mem[r_ptr low bits], and r_ptr increments. Otherwise data_out holds its value.
- count update: +1 on wr_ok only, −1 on rd_ok only, unchanged when both or neither occur.
- Status flags: full, empty, almost_full and almost_empty are decoded from registered state only. There is no combinational path from w_en or r_en to any flag.
- Consistency: full must equal (w_ptr == {~r_ptr MSB, r_ptr low bits}), and empty must equal (w_ptr == r_ptr). Both checks must agree with count at all times.
- Reset: w_ptr=0, r_ptr=0, count=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0) → 0 for legal values, overflow=0, underflow=0. Memory contents are not reset.
- Reset mid-operation: all state returns to the reset values asynchronously. Any in-flight data is discarded.

## Timing
- Write-to-flag latency: an accepted write at edge N updates count, empty and almost_* after edge N. The new values are visible in the cycle following edge N.
- Write-to-read latency: the earliest read of a written word is accepted at edge N+1. data_out is valid after edge N+1, giving 2 edges from the write.
- Read latency: data_out is valid 1 cycle after the accepting edge.
- Full + w_en + r_en: both are accepted; count stays at DEPTH and full stays high.
- Empty + w_en + r_en: the write is accepted and the read is rejected; count becomes 1.

## Configuration
- SYNC_FIFO_ERR_EN defined: adds err_clr, overflow and underflow.
  - overflow sets on (w_en && !wr_ok); underflow sets on (r_en && !rd_ok).
  - Both flags stay set until err_clr=1 or rst.
  - If a set event and err_clr occur in the same cycle, set wins.
- SYNC_FIFO_ERR_EN undefined: those three ports and their logic are absent. Rejected requests are silently dropped.

## Structure
- Package synchronous_fifo_pkg holds:
  - the CNT_W/PTR_W width calculation function;
  - typedef fifo_status_t, a struct of full, empty, almost_full, almost_empty;
  - typedef fifo_err_t, a struct of overflow, underflow.
- Sub-module synchronous_fifo_mem holds the storage array: one write port and one registered read port with a read-enable. The top level keeps the pointers, count, flags and error logic.

## Test plan
DEPTH=16, DATA_WIDTH=32, AF_LEVEL=14, AE_LEVEL=2 unless stated.
- Reset: assert rst mid-cycle → immediately count=0, empty=1, almost_empty=1, full=0, data_out=0.
- Fill and drain: write 0x1..0x10 → after the 14th write almost_full=1, after the 16th write full=1. Then read 16 times → data_out sequence is 0x1..0x10, and empty=1 after the last read.
- Wrap-around: write 10, read 10, write 16, read 16 → data order is preserved and count returns to 0. Pointer MSBs toggle without a spurious full or empty.
- Full with simultaneous access: at count=16, w_en=r_en=1 with data 0xAA → count stays 16, data_out=oldest word, and 0xAA is read back last.
- Empty with simultaneous access: at count=0, w_en=r_en=1 with 0x55 → count=1, data_out unchanged. The next read returns 0x55.
- Errors (ERR_EN built): write while full without a read → overflow=1 and count stays 16. Read while empty → underflow=1. err_clr=1 → both flags return to 0. Without the macro, the same stimulus leaves count and data unchanged.
